// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA frame buffer types and default geometry
package vga_pkg;

  typedef enum logic [1:0] {
    HUNT = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fw_state_t;

  localparam int unsigned default_data_width = 12;
  localparam int unsigned default_horiz      = 640;
  localparam int unsigned default_vert       = 480;
  localparam int unsigned default_h_width    = 10;
  localparam int unsigned default_v_width    = 10;
  localparam int unsigned default_addr_width = 19;

endpackage

// File: rtl/frame_writer.sv
// rtl/frame_writer.sv - raster pixel stream to linear frame buffer writes
module frame_writer
  import vga_pkg::*;
#(
  parameter int unsigned data_width = default_data_width,
  parameter int unsigned horiz      = default_horiz,
  parameter int unsigned vert       = default_vert,
  parameter int unsigned h_width    = default_h_width,
  parameter int unsigned v_width    = default_v_width,
  parameter int unsigned addr_width = default_addr_width
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [data_width-1:0] s_data,
  input  logic                  s_sof,
  input  logic                  s_eol,
  output logic                  wr_en,
  output logic [addr_width-1:0] wr_addr,
  output logic [data_width-1:0] wr_data,
  output logic                  frame_done,
  output logic                  err,
  output logic [7:0]            frame_cnt
);

  localparam logic [h_width-1:0] x_last = h_width'(horiz - 1);
  localparam logic [v_width-1:0] y_last = v_width'(vert - 1);

  fw_state_t             state, state_next;
  logic [h_width-1:0]    x;
  logic [v_width-1:0]    y;
  logic [addr_width-1:0] addr;

  logic accept, at_x_last, last_pix;
  logic do_write, do_sof, do_err, do_last;

  assign accept    = s_valid && s_ready;
  assign at_x_last = (x == x_last);
  assign last_pix  = at_x_last && (y == y_last) && s_eol;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= HUNT;
    else        state <= state_next;
  end

  // Framing checks in RUN are ordered: a fresh sof always wins over marker errors.
  always_comb begin
    state_next = state;
    do_write   = 1'b0;
    do_sof     = 1'b0;
    do_err     = 1'b0;
    do_last    = 1'b0;
    case (state)
      HUNT: begin
        if (accept && s_sof) begin
          do_write   = 1'b1;
          do_sof     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (accept) begin
          if (s_sof) begin
            do_err   = 1'b1;
            do_write = 1'b1;
            do_sof   = 1'b1;
          end else if (s_eol && !at_x_last) begin
            do_err     = 1'b1;
            state_next = HUNT;
          end else if (at_x_last && !s_eol) begin
            do_err     = 1'b1;
            state_next = HUNT;
          end else begin
            do_write = 1'b1;
            if (last_pix) begin
              do_last    = 1'b1;
              state_next = DONE;
            end
          end
        end
      end
      DONE:    state_next = HUNT;
      default: state_next = HUNT;
    endcase
  end

  always_comb begin
    s_ready = (state != DONE);
  end

  // addr runs one ahead of the beat being written, so wr_addr == y*horiz+x without a multiply.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x          <= '0;
      y          <= '0;
      addr       <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      frame_done <= 1'b0;
      err        <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      wr_en      <= do_write;
      err        <= do_err;
      frame_done <= do_last;
      if (do_write) begin
        wr_data <= s_data;
        wr_addr <= do_sof ? '0 : addr;
      end
      if (do_sof) begin
        addr <= addr_width'(1);
        x    <= h_width'(1);
        y    <= '0;
      end else if (do_write) begin
        addr <= addr + addr_width'(1);
        if (at_x_last) begin
          x <= '0;
          y <= do_last ? '0 : y + v_width'(1);
        end else begin
          x <= x + h_width'(1);
        end
      end
      if (do_last) frame_cnt <= frame_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_frame_writer.sv
// tb/tb_frame_writer.sv - scoreboard bench for frame_writer on an 8x4 frame
module tb_frame_writer;

  localparam int dw = 12;
  localparam int hz = 8;
  localparam int vt = 4;
  localparam int aw = 19;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [dw-1:0] s_data = '0;
  logic          s_sof = 1'b0;
  logic          s_eol = 1'b0;
  logic          wr_en;
  logic [aw-1:0] wr_addr;
  logic [dw-1:0] wr_data;
  logic          frame_done;
  logic          err;
  logic [7:0]    frame_cnt;

  frame_writer #(
    .data_width(dw), .horiz(hz), .vert(vt),
    .h_width(10), .v_width(10), .addr_width(aw)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_sof(s_sof), .s_eol(s_eol),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .frame_done(frame_done), .err(err), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int wr_cnt = 0, err_cnt = 0, done_cnt = 0, nrdy_cnt = 0;
  logic [aw-1:0] q_addr[$];
  logic [dw-1:0] q_data[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (!s_ready) nrdy_cnt++;
      if (err) err_cnt++;
      if (frame_done) begin
        done_cnt++;
        check_eq("done_with_wr", 32'(wr_en), 32'd1);
      end
      if (wr_en) begin
        wr_cnt++;
        if (q_addr.size() == 0) begin
          check_eq("wr_unexpected", 32'(wr_en), 32'd0);
        end else begin
          check_eq("wr_addr", 32'(wr_addr), 32'(q_addr.pop_front()));
          check_eq("wr_data", 32'(wr_data), 32'(q_data.pop_front()));
        end
      end
    end
  end

  task automatic beat(input logic [dw-1:0] d, input logic sof, input logic eol,
                      input logic expect_wr, input logic [aw-1:0] ea);
    int n = 0;
    @(negedge clk);
    s_valid = 1'b1;
    s_data  = d;
    s_sof   = sof;
    s_eol   = eol;
    while (!s_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (n >= 10) check_eq("ready_timeout", 32'(s_ready), 32'd1);
    if (expect_wr) begin
      q_addr.push_back(ea);
      q_data.push_back(d);
    end
    @(posedge clk);
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      s_valid = 1'b0;
      s_sof   = 1'b0;
      s_eol   = 1'b0;
    end
  endtask

  // Sends the first npix beats of a correctly framed image.
  task automatic frame(input int npix, input bit gaps);
    for (int p = 0; p < npix; p++) begin
      if (gaps && $urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
      beat(dw'($urandom), p == 0, (p % hz) == hz - 1, 1'b1, aw'(p));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int e0, w0;
    repeat (2) @(negedge clk);
    check_eq("rst_wr_en", 32'(wr_en), 0);
    check_eq("rst_wr_addr", 32'(wr_addr), 0);
    check_eq("rst_wr_data", 32'(wr_data), 0);
    check_eq("rst_frame_done", 32'(frame_done), 0);
    check_eq("rst_err", 32'(err), 0);
    check_eq("rst_frame_cnt", 32'(frame_cnt), 0);
    check_eq("rst_s_ready", 32'(s_ready), 1);
    rst_n = 1'b1;

    // clean frame, continuous valid
    nrdy_cnt = 0;
    frame(hz * vt, 1'b0);
    idle(4);
    check_eq("clean_writes", 32'(wr_cnt), 32);
    check_eq("clean_done", 32'(done_cnt), 1);
    check_eq("clean_frame_cnt", 32'(frame_cnt), 1);
    check_eq("clean_ready_low", 32'(nrdy_cnt), 1);
    check_eq("clean_err", 32'(err_cnt), 0);

    // leading garbage then clean frame
    w0 = wr_cnt;
    for (int i = 0; i < 5; i++) beat(dw'($urandom), 1'b0, i == 2, 1'b0, '0);
    idle(3);
    check_eq("garbage_no_wr", 32'(wr_cnt - w0), 0);
    check_eq("garbage_no_err", 32'(err_cnt), 0);
    frame(hz * vt, 1'b0);
    idle(4);
    check_eq("garbage_frame_cnt", 32'(frame_cnt), 2);

    // early eol at x=3 of line 1
    e0 = err_cnt;
    w0 = wr_cnt;
    frame(hz + 3, 1'b0);
    beat(dw'($urandom), 1'b0, 1'b1, 1'b0, '0);
    for (int i = 0; i < 4; i++) beat(dw'($urandom), 1'b0, 1'b0, 1'b0, '0);
    idle(4);
    check_eq("eol_err", 32'(err_cnt - e0), 1);
    check_eq("eol_writes", 32'(wr_cnt - w0), 32'(hz + 3));
    check_eq("eol_frame_cnt", 32'(frame_cnt), 2);
    frame(hz * vt, 1'b0);
    idle(4);
    check_eq("eol_recover_cnt", 32'(frame_cnt), 3);

    // sof mid-frame at pixel 10
    e0 = err_cnt;
    w0 = done_cnt;
    frame(10, 1'b0);
    frame(hz * vt, 1'b0);
    idle(4);
    check_eq("sof_err", 32'(err_cnt - e0), 1);
    check_eq("sof_done", 32'(done_cnt - w0), 1);
    check_eq("sof_frame_cnt", 32'(frame_cnt), 4);

    // gaps, then reset mid-frame
    frame(13, 1'b1);
    idle(3);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_wr_en", 32'(wr_en), 0);
    check_eq("mid_rst_wr_addr", 32'(wr_addr), 0);
    check_eq("mid_rst_frame_cnt", 32'(frame_cnt), 0);
    check_eq("mid_rst_err", 32'(err), 0);
    check_eq("mid_rst_s_ready", 32'(s_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    w0 = done_cnt;
    frame(hz * vt, 1'b1);
    idle(4);
    check_eq("post_rst_frame_cnt", 32'(frame_cnt), 1);
    check_eq("post_rst_done", 32'(done_cnt - w0), 1);
    check_eq("sb_empty", 32'(q_addr.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/frame_writer.md
# frame_writer

Write-side stage of the VGA frame buffer. Accepts a raster-ordered pixel stream with a valid/ready handshake, tracks x/y position and converts it into linear write addresses for `rgb_data_mem`. Frames whose framing markers are wrong are rejected and resynchronised at the next start-of-frame. It sits directly upstream of the memory, whose read side feeds the display timing path.

## Interface
- `data_width`, 12: pixel width (4:4:4 RGB)
- `horiz`, 640: active pixels per line
- `vert`, 480: active lines per frame
- `h_width`, 10: x counter width
- `v_width`, 10: y counter width
- `addr_width`, 19: memory address width

Ports:
- `clk`  in  1  pixel/system clock; one clock domain
- `rst_n`  in  1  asynchronous, active-low reset
- `s_valid`  in  1  stream beat valid
- `s_ready`  out  1  stream beat accepted when `s_valid && s_ready`
- `s_data`  in  data_width  pixel value
- `s_sof`  in  1  beat is pixel (0,0)
- `s_eol`  in  1  beat is last pixel of its line
- `wr_en`  out  1  memory write strobe
- `wr_addr`  out  addr_width  linear address y*horiz+x
- `wr_data`  out  data_width  pixel to write
- `frame_done`  out  1  one-cycle pulse after the final pixel of a clean frame is written
- `err`  out  1  one-cycle pulse on a framing error
- `frame_cnt`  out  8  count of clean frames, wraps 255->0

## Operation
- FSM states: HUNT, RUN, DONE. Reset state is HUNT.
- `s_ready` = (state != DONE). It is a decode of registered state only, with no combinational path from `s_valid`.
- HUNT:
  - Accepted beats without `s_sof` are discarded.
  - A beat with `s_sof` is written at address 0, sets x=1, y=0 and moves to RUN.
- RUN, accepted beat, checks in priority order:
  1. `s_sof`: pulse `err`, write at address 0, restart the counters with x=1, y=0, stay in RUN.
  2. `s_eol` with x != horiz-1: pulse `err`, do not write, go to HUNT.
  3. x == horiz-1 without `s_eol`: pulse `err`, do not write, go to HUNT.
  4. Otherwise write the beat. If x == horiz-1, set x=0 and y++. If the beat is the last pixel (x == horiz-1, y == vert-1, `s_eol`), go to DONE.
- DONE: lasts exactly one cycle, then returns to HUNT. `s_ready`=0 for that cycle.
- Address generation: a running counter, not a multiplier. It resets to 0 on sof and increments by 1 per written beat. It must equal y*horiz+x. Width is addr_width, with no wrap within a frame (horiz*vert-1 = 307199 < 2^19).
- `frame_cnt` increments in the same cycle `frame_done` is high.
- Beats with `s_valid`=0 change nothing.

## Timing
- Write latency: 1 cycle. `wr_en`, `wr_addr` and `wr_data` are registered and valid in the cycle after the accepted beat. `wr_en` is high for exactly one cycle per written beat.
- `err` is registered and asserts 1 cycle after the offending beat.
- `frame_done` asserts in the cycle DONE is occupied, which coincides with the final `wr_en`.
- Sustained throughput: 1 beat per cycle, except for the single DONE bubble per frame.
- Reset values:
  - `wr_en`=0, `wr_addr`=0, `wr_data`=0, `frame_done`=0, `err`=0, `frame_cnt`=0
  - x=0, y=0, state HUNT, so `s_ready`=1
- Reset asserted mid-frame: everything clears immediately, with no partial-frame `frame_done`. After release, the block hunts for sof.

## Structure
- `vga_pkg` holds:
  - the FSM state enum (`fw_state_t`: HUNT, RUN, DONE)
  - the default constants for data_width, horiz, vert, h_width, v_width and addr_width, shared with `VGA_TOP` and `rgb_data_mem`.
- No sub-module is needed. The x/y counters, the address counter and the FSM live in a single module of about 150–250 lines.

## Test plan
- Clean frame, horiz=8, vert=4 override, continuous valid: 32 writes with addresses 0..31 in order. `frame_done` is high with write 31. `frame_cnt`=1. `s_ready` is low for exactly 1 cycle.
- Leading garbage: 5 beats without sof, then a clean frame. The first 5 beats produce no `wr_en`, and the first write has addr 0.
- Early eol at x=3 of line 1: `err` pulses once, the beat is not written, and the block stays in HUNT with no writes until the next sof.
- Sof mid-frame at pixel 10: `err` pulses, the next write is addr 0, and a following clean frame completes with `frame_done`.
- Random `s_valid` gaps and `rst_n` pulsed low mid-frame: all outputs are 0 and `s_ready`=1 during reset. After release, a clean frame yields addresses 0..31 and `frame_cnt`=1.
